// File: rtl/line_loader_pkg.sv
// Shared types for the UART line loader: command characters, FSM states,
// the decoded-character record and the hex digit helper.
package line_loader_pkg;

  localparam logic [7:0] CH_RESET  = 8'h23;  // '#'
  localparam logic [7:0] CH_COMMIT = 8'h2B;  // '+'

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_ADVANCE} state_t;
  typedef enum logic [1:0] {C_OTHER, C_HEX, C_RESET, C_COMMIT} cls_t;

  typedef struct packed {
    logic       stb;
    cls_t       cls;
    logic [3:0] nib;
  } dec_t;

  // {valid, value}; letters map through the low nibble (A/a = x1) plus 9
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    logic ok;
    ok = (c >= 8'h30 && c <= 8'h39) ||
         (c >= 8'h41 && c <= 8'h46) ||
         (c >= 8'h61 && c <= 8'h66);
    return {ok, c[3:0] + (c[6] ? 4'd9 : 4'd0)};
  endfunction

endpackage

// File: rtl/uart_line_loader_hex_char_decode.sv
// Registered byte classifier: detects the i_READY rising edge and emits one
// strobe per byte with its character class and hex value a cycle later.
module hex_char_decode
  import line_loader_pkg::*;
(
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_READY,
  input  logic [7:0] i_DATA,
  output dec_t       o_DEC
);

  logic       rdy_q;
  logic [4:0] nv;
  cls_t       cls;

  always_comb begin
    nv  = hex_to_nibble(i_DATA);
    cls = C_OTHER;
    if (nv[4])                   cls = C_HEX;
    else if (i_DATA == CH_RESET)  cls = C_RESET;
    else if (i_DATA == CH_COMMIT) cls = C_COMMIT;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      rdy_q <= 1'b0;
      o_DEC <= '0;
    end else begin
      rdy_q     <= i_READY;
      o_DEC.stb <= i_READY & ~rdy_q;
      o_DEC.cls <= cls;
      o_DEC.nib <= nv[3:0];
    end
  end

endmodule

// File: rtl/uart_line_loader.sv
// Assembles one line of 1-bit pixels from hex text on the UART byte stream
// and writes each committed line into the PAL line BRAM.
module uart_line_loader
  import line_loader_pkg::*;
#(
  parameter int PIXELS = 300,
  parameter int LINES  = 608,
  parameter int ADDR_W = 10
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_READY,
  input  logic [7:0]        i_DATA,
  output logic              o_WR_EN,
  output logic [ADDR_W-1:0] o_WR_ADDR,
  output logic [PIXELS-1:0] o_WR_DATA,
  output logic [ADDR_W-1:0] o_LINE_IDX,
  output logic              o_FRAME_DONE,
  output logic              o_OVERFLOW
);

  localparam int NIBBLES = PIXELS / 4;
  localparam int K_W     = $clog2(NIBBLES + 1);

  dec_t              dec, pend_dec, act;
  logic              pend, act_stb, line_last, ovf;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] line, wr_addr_q;
  logic [K_W-1:0]    k;
  logic [PIXELS-1:0] accum, wr_data_q;

  hex_char_decode u_dec (
    .i_CLK   (i_CLK),
    .i_RST_N (i_RST_N),
    .i_READY (i_READY),
    .i_DATA  (i_DATA),
    .o_DEC   (dec)
  );

  // A byte parked during commit/advance takes priority once back in idle
  assign act       = pend ? pend_dec : dec;
  assign act_stb   = (state == S_IDLE) && act.stb;
  assign line_last = (line == ADDR_W'(LINES - 1));

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_WR_EN      = 1'b0;
    o_FRAME_DONE = 1'b0;
    case (state)
      S_IDLE:    if (act_stb && act.cls == C_COMMIT) state_nxt = S_COMMIT;
      S_COMMIT:  begin
        o_WR_EN   = 1'b1;
        state_nxt = S_ADVANCE;
      end
      S_ADVANCE: begin
        o_FRAME_DONE = line_last;
        state_nxt    = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      pend      <= 1'b0;
      pend_dec  <= '0;
      line      <= '0;
      k         <= '0;
      accum     <= '0;
      ovf       <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pend) begin
            pend     <= dec.stb;
            pend_dec <= dec;
          end
          if (act_stb) begin
            case (act.cls)
              C_HEX: begin
                if (k < K_W'(NIBBLES)) begin
                  accum[{k, 2'b00} +: 4] <= act.nib;
                  k                      <= k + 1'b1;
                end else begin
                  ovf <= 1'b1;
                end
              end
              C_RESET: begin
                accum <= '0;
                k     <= '0;
                line  <= '0;
                ovf   <= 1'b0;
              end
              C_COMMIT: begin
                wr_addr_q <= line;
                wr_data_q <= accum;
              end
              default: ;
            endcase
          end
        end
        S_COMMIT: begin
          if (dec.stb) begin
            pend     <= 1'b1;
            pend_dec <= dec;
          end
        end
        S_ADVANCE: begin
          if (dec.stb) begin
            pend     <= 1'b1;
            pend_dec <= dec;
          end
          accum <= '0;
          k     <= '0;
          line  <= line_last ? '0 : line + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_WR_ADDR  = wr_addr_q;
  assign o_WR_DATA  = wr_data_q;
  assign o_LINE_IDX = line;
  assign o_OVERFLOW = ovf;

endmodule

// File: tb/tb_uart_line_loader.sv
// Directed bench for uart_line_loader: hex parsing, commit/advance, overflow,
// frame wrap and asynchronous reset during a write.
module tb_uart_line_loader;

  localparam int PIXELS = 300;
  localparam int LINES  = 608;
  localparam int ADDR_W = 10;

  logic              i_CLK = 1'b0;
  logic              i_RST_N = 1'b0;
  logic              i_READY = 1'b0;
  logic [7:0]        i_DATA = 8'h00;
  logic              o_WR_EN;
  logic [ADDR_W-1:0] o_WR_ADDR;
  logic [PIXELS-1:0] o_WR_DATA;
  logic [ADDR_W-1:0] o_LINE_IDX;
  logic              o_FRAME_DONE;
  logic              o_OVERFLOW;

  uart_line_loader #(.PIXELS(PIXELS), .LINES(LINES), .ADDR_W(ADDR_W)) dut (
    .i_CLK        (i_CLK),
    .i_RST_N      (i_RST_N),
    .i_READY      (i_READY),
    .i_DATA       (i_DATA),
    .o_WR_EN      (o_WR_EN),
    .o_WR_ADDR    (o_WR_ADDR),
    .o_WR_DATA    (o_WR_DATA),
    .o_LINE_IDX   (o_LINE_IDX),
    .o_FRAME_DONE (o_FRAME_DONE),
    .o_OVERFLOW   (o_OVERFLOW)
  );

  always #5 i_CLK = ~i_CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [PIXELS-1:0] act, input logic [PIXELS-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // write / frame-done monitor
  int                wr_cnt = 0;
  int                fd_cnt = 0;
  int                fd_line = -1;
  int                exp_seq = 0;
  bit                seq_on = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [PIXELS-1:0] last_data = '0;

  always @(negedge i_CLK) begin
    if (i_RST_N) begin
      if (o_WR_EN) begin
        wr_cnt++;
        last_addr = o_WR_ADDR;
        last_data = o_WR_DATA;
        if (seq_on) begin
          chk("seq_addr", PIXELS'(o_WR_ADDR), PIXELS'(exp_seq));
          exp_seq++;
        end
      end
      if (o_FRAME_DONE) begin
        fd_cnt++;
        fd_line = int'(o_LINE_IDX);
      end
    end
  end

  task automatic send_hold(input logic [7:0] c, input int hold);
    @(negedge i_CLK);
    i_DATA  = c;
    i_READY = 1'b1;
    repeat (hold) @(negedge i_CLK);
    i_READY = 1'b0;
    repeat (4) @(negedge i_CLK);
  endtask

  task automatic send(input logic [7:0] c);
    send_hold(c, 4);
  endtask

  int  base;
  bit  found;

  initial begin
    repeat (3) @(negedge i_CLK);
    chk("rst_wr_en",   PIXELS'(o_WR_EN), 0);
    chk("rst_wr_addr", PIXELS'(o_WR_ADDR), 0);
    chk("rst_wr_data", o_WR_DATA, 0);
    chk("rst_line",    PIXELS'(o_LINE_IDX), 0);
    chk("rst_fd",      PIXELS'(o_FRAME_DONE), 0);
    chk("rst_ovf",     PIXELS'(o_OVERFLOW), 0);
    i_RST_N = 1'b1;
    repeat (2) @(negedge i_CLK);

    // "#F0+"
    base = wr_cnt;
    send("#"); send("F"); send("0"); send("+");
    chk("t1_wr_cnt", PIXELS'(wr_cnt - base), 1);
    chk("t1_addr",   PIXELS'(last_addr), 0);
    chk("t1_data",   last_data, 300'hF);
    chk("t1_line",   PIXELS'(o_LINE_IDX), 1);
    chk("t1_wr_low", PIXELS'(o_WR_EN), 0);

    // long i_READY on 'A' absorbs one nibble
    base = wr_cnt;
    send_hold("A", 500);
    send("+");
    chk("t2_wr_cnt", PIXELS'(wr_cnt - base), 1);
    chk("t2_addr",   PIXELS'(last_addr), 1);
    chk("t2_data",   last_data, 300'hA);
    chk("t2_line",   PIXELS'(o_LINE_IDX), 2);

    // 76 digits: overflow on the last one
    for (int i = 0; i < 75; i++) send("F");
    chk("t3_ovf_75", PIXELS'(o_OVERFLOW), 0);
    send("F");
    chk("t3_ovf_76", PIXELS'(o_OVERFLOW), 1);
    send("+");
    chk("t3_addr",   PIXELS'(last_addr), 2);
    chk("t3_data",   last_data, {PIXELS{1'b1}});
    chk("t3_ovf_kept", PIXELS'(o_OVERFLOW), 1);
    send("#");
    chk("t3_ovf_clr", PIXELS'(o_OVERFLOW), 0);
    chk("t3_line",   PIXELS'(o_LINE_IDX), 0);

    // full frame of empty commits
    base    = wr_cnt;
    exp_seq = 0;
    fd_cnt  = 0;
    seq_on  = 1'b1;
    for (int i = 0; i < LINES; i++) send("+");
    seq_on = 1'b0;
    chk("t4_wr_cnt", PIXELS'(wr_cnt - base), LINES);
    chk("t4_seq_end", PIXELS'(exp_seq), LINES);
    chk("t4_fd_cnt", PIXELS'(fd_cnt), 1);
    chk("t4_fd_line", PIXELS'(fd_line), LINES - 1);
    chk("t4_line",   PIXELS'(o_LINE_IDX), 0);
    chk("t4_data",   last_data, 0);

    // lowercase and ignored control characters
    base = wr_cnt;
    send("#"); send("a"); send(8'h0D); send(8'h0A); send("B"); send("+");
    chk("t5_wr_cnt", PIXELS'(wr_cnt - base), 1);
    chk("t5_addr",   PIXELS'(last_addr), 0);
    chk("t5_data",   last_data, 300'hBA);
    chk("t5_line",   PIXELS'(o_LINE_IDX), 1);

    // reset during the write pulse
    @(negedge i_CLK);
    i_DATA  = "+";
    i_READY = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge i_CLK);
      if (o_WR_EN) found = 1'b1;
    end
    chk("t6_commit_seen", PIXELS'(found), 1);
    #1;
    i_RST_N = 1'b0;
    i_READY = 1'b0;
    #1;
    chk("t6_abort", PIXELS'(o_WR_EN), 0);
    chk("t6_line_rst", PIXELS'(o_LINE_IDX), 0);
    repeat (2) @(negedge i_CLK);
    i_RST_N = 1'b1;
    repeat (2) @(negedge i_CLK);
    chk("t6_line_rel", PIXELS'(o_LINE_IDX), 0);
    base = wr_cnt;
    send("+");
    chk("t6_wr_cnt", PIXELS'(wr_cnt - base), 1);
    chk("t6_addr",   PIXELS'(last_addr), 0);
    chk("t6_data",   last_data, 0);
    chk("t6_line",   PIXELS'(o_LINE_IDX), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_line_loader.md
Name: uart_line_loader

Overview:
- Upstream stage of the PAL frame path: consumes the byte stream from uart_rx and assembles one display line of 1-bit pixels from hex text.
- Writes each completed line into the line BRAM read by the PAL state machine.
- Replaces ad-hoc parsing with a defined protocol:
  - '#' resets to line 0.
  - hex digits fill pixels left to right.
  - '+' commits the current line and advances to the next one.

Parameters:
- PIXELS, 300, pixels per line; must be a multiple of 4 (NIBBLES = PIXELS/4 = 75).
- LINES, 608, BRAM depth in lines; line index wraps at LINES-1.
- ADDR_W, 10, BRAM address width; 2**ADDR_W >= LINES.

Ports:
- i_CLK  in  1  system clock (27 MHz domain, same clock as uart_rx and the BRAM write port).
- i_RST_N  in  1  asynchronous active-low reset.
- i_READY  in  1  uart_rx o_READY; level, high while i_DATA is valid.
- i_DATA  in  8  uart_rx o_DATA.
- o_WR_EN  out  1  BRAM write enable; one-cycle pulse.
- o_WR_ADDR  out  ADDR_W  BRAM write address.
- o_WR_DATA  out  PIXELS  BRAM write data; bit 0 is the leftmost pixel.
- o_LINE_IDX  out  ADDR_W  line currently being assembled.
- o_FRAME_DONE  out  1  one-cycle pulse when the line index wraps LINES-1 -> 0.
- o_OVERFLOW  out  1  sticky flag: a hex digit arrived after NIBBLES digits on the current line.

Behaviour:
- Clock and reset: one clock i_CLK; reset i_RST_N is asynchronous, active-low.
- On reset: all outputs 0. Internal state is cleared to:
  - line index 0, nibble count 0, accumulator 0;
  - FSM in S_IDLE;
  - i_READY history 0.
- Byte strobe: rising edge of registered i_READY. Exactly one strobe per byte regardless of how long i_READY stays high.
- Character classes:
  - hex: '0'-'9', 'A'-'F', 'a'-'f'.
  - CMD_RESET: '#'.
  - CMD_COMMIT: '+'.
  - anything else (CR, LF, space, etc.) is ignored with no state change.
- Hex nibble mapping:
  - The k-th hex digit since the last commit/reset writes accum[4k+3:4k] = value.
  - Value LSB is the leftmost pixel of that group.
  - Only when k < NIBBLES; then k increments.
  - When k == NIBBLES: the digit is dropped, o_OVERFLOW is set to 1, k is unchanged.
- FSM S_IDLE -> S_COMMIT -> S_ADVANCE -> S_IDLE:
  - S_IDLE: on strobe, hex digits are absorbed in the same cycle with no state change.
    - '#' (in S_IDLE): accum <= 0, k <= 0, line <= 0, o_OVERFLOW <= 0. No write, no o_FRAME_DONE.
    - '+' (in S_IDLE): go to S_COMMIT.
  - S_COMMIT (1 cycle): o_WR_EN=1, o_WR_ADDR=line, o_WR_DATA=accum.
  - S_ADVANCE (1 cycle):
    - accum <= 0, k <= 0;
    - line <= (line==LINES-1) ? 0 : line+1;
    - o_FRAME_DONE=1 iff wrap.
- Timing and latency:
  - Strobe to o_WR_EN for '+' is 1 cycle.
  - o_WR_EN is low at all other times.
  - o_WR_ADDR/o_WR_DATA hold their last values outside the pulse.
- Partial line: undefined pixels are 0 (black); a '+' with k=0 writes an all-zero line.
- Strobe in S_COMMIT or S_ADVANCE:
  - latched into a single pending flag plus byte register;
  - processed in S_IDLE on the next cycle.
  - A second strobe while pending is set overwrites it (not reachable at 115200 baud, where bytes arrive about 2340 cycles apart).
- '#' pending during a commit: the commit completes first (write happens), then the reset applies.
- Reset asserted mid-commit: the write pulse is aborted immediately (async), no partial advance.
- o_LINE_IDX always reflects the registered line index.
- All arithmetic is unsigned; the line comparison uses full ADDR_W width.

Decomposition:
- Package line_loader_pkg contains:
  - character constants CH_RESET='#' and CH_COMMIT='+';
  - FSM enum {S_IDLE, S_COMMIT, S_ADVANCE};
  - function hex_to_nibble returning {valid, value[3:0]}.
- One sub-module hex_char_decode: registered classifier (strobe edge detect + class + nibble). It adds 1 cycle to the pipeline; that cycle is included in the latency above by treating its output as the strobe.

Test Plan:
- Reset, then "#", "F0", "+" -> one o_WR_EN pulse with addr 0, data[3:0]=0xF, data[7:4]=0x0, all other bits 0; o_LINE_IDX=1.
- i_READY held high for 500 cycles on "A" -> exactly one nibble absorbed; after "+", data[3:0]=0xA.
- 76 hex digits "F"x76, then "+" -> data all ones (300 bits); o_OVERFLOW=1 after the 76th digit; "#" clears it to 0.
- 608 repetitions of "+" -> 608 writes to addrs 0..607; o_FRAME_DONE pulses once, coincident with line 607 -> 0.
- "#", "a", "\r", "\n", "B", "+" -> lowercase accepted, CR/LF ignored; data[7:0]=0xBA; o_LINE_IDX=1.
- Deassert i_RST_N during S_COMMIT -> o_WR_EN drops to 0 asynchronously; after release, o_LINE_IDX=0 and the next "+" writes addr 0 with data 0.
